multi_axis_step_gen: RTL and testbench

Parametrised multi-axis step/direction generator for the robot motion CPLD. Each control period is divided into SLOTS pulse slots. For every axis, a signed per-period step count is spread evenly across the period with a DDA accumulator. Commands are double-buffered per axis, so the host can queue the next period's count while the current one plays out; missed updates are flagged as underruns.

---
 rtl/multi_axis_step_pkg.sv | 29 ++
 rtl/step_dda_channel.sv | 119 +++++++++++
 rtl/multi_axis_step_gen.sv | 138 +++++++++++++
 tb/tb_multi_axis_step_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_axis_step_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_axis_step_pkg
//  Brief    : Shared width helpers and command layout for the step generator.
//  Revision : 1.0  initial release
// ============================================================================
package multi_axis_step_pkg;

   // Default magnitude width of a per-period step count.
   localparam int CNT_W_DFLT = 9;

   // Accumulator must hold (SLOTS-1) + (SLOTS-1) without overflow.
   function automatic int acc_width(input int slots);
      return $clog2(2 * slots);
   endfunction

   // Axis index width; a single-axis build still gets a 1-bit select.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Command word layout at the default count width: {direction, count}.
   typedef struct packed {
      logic                  dir;
      logic [CNT_W_DFLT-1:0] count;
   } step_cmd_t;

endpackage
`default_nettype wire

// File: rtl/step_dda_channel.sv
`default_nettype none
// ============================================================================
//  Module   : step_dda_channel
//  Brief    : One step/dir axis: double-buffered command, DDA spreading of
//             the period count across slots, fixed-width step pulse.
//  Revision : 1.0  initial release
// ============================================================================
module step_dda_channel #(
   parameter int CNT_W    = 9,
   parameter int SLOTS    = 500,
   parameter int PULSE_HI = 200,
   parameter int ACC_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_run,
   input  logic             i_boundary,
   input  logic             i_eval,
   input  logic             i_wr,
   input  logic [CNT_W:0]   i_wr_data,
   output logic             o_step,
   output logic             o_dir,
   output logic             o_busy,
   output logic             o_pend_valid
);

   localparam int PW_W = (PULSE_HI > 1) ? $clog2(PULSE_HI) : 1;

   localparam logic [ACC_W-1:0] c_acc_init = ACC_W'(SLOTS - 1);
   localparam logic [ACC_W-1:0] c_acc_wrap = ACC_W'(SLOTS);
   localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(SLOTS - 1);
   localparam logic [PW_W-1:0]  c_pw_load  = PW_W'(PULSE_HI - 1);

   logic             r_pend_dir;
   logic [CNT_W-1:0] r_pend_cnt;
   logic             r_pend_valid;
   logic [CNT_W-1:0] r_active;
   logic [ACC_W-1:0] r_acc;
   logic             r_dir;
   logic             r_step;
   logic [PW_W-1:0]  r_pw;

   logic [CNT_W-1:0] w_wr_cnt;
   logic [ACC_W-1:0] w_sum;
   logic             w_carry;

   // More pulses than slots cannot be issued, so clamp at write time.
   assign w_wr_cnt = (i_wr_data[CNT_W-1:0] > c_cnt_max) ? c_cnt_max
                                                        : i_wr_data[CNT_W-1:0];

   // Active count never exceeds SLOTS-1, so it always fits the accumulator.
   assign w_sum   = r_acc + ACC_W'(r_active);
   assign w_carry = (w_sum >= c_acc_wrap);

   // Pending buffer: a write always lands here; a boundary without a write
   // drains it.  A write coincident with a boundary survives for next period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_dir   <= 1'b0;
         r_pend_cnt   <= '0;
         r_pend_valid <= 1'b0;
      end else if (i_wr) begin
         r_pend_dir   <= i_wr_data[CNT_W];
         r_pend_cnt   <= w_wr_cnt;
         r_pend_valid <= 1'b1;
      end else if (i_boundary) begin
         r_pend_valid <= 1'b0;
      end
   end

   // Active command, direction and DDA accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= '0;
         r_dir    <= 1'b0;
         r_acc    <= c_acc_init;
      end else if (!i_run) begin
         r_active <= '0;
         r_acc    <= c_acc_init;
      end else if (i_boundary) begin
         r_acc <= c_acc_init;
         if (r_pend_valid) begin
            r_active <= r_pend_cnt;
            r_dir    <= r_pend_dir;
         end else begin
            r_active <= '0;
         end
      end else if (i_eval) begin
         r_acc <= w_carry ? (w_sum - c_acc_wrap) : w_sum;
      end
   end

   // Step pulse: rises after a carrying evaluation, held PULSE_HI cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step <= 1'b0;
         r_pw   <= '0;
      end else if (!i_run) begin
         r_step <= 1'b0;
         r_pw   <= '0;
      end else if (i_eval && w_carry) begin
         r_step <= 1'b1;
         r_pw   <= c_pw_load;
      end else if (r_step) begin
         if (r_pw == '0) begin
            r_step <= 1'b0;
         end else begin
            r_pw <= r_pw - 1'b1;
         end
      end
   end

   assign o_step       = r_step;
   assign o_dir        = r_dir;
   assign o_busy       = (r_active != '0);
   assign o_pend_valid = r_pend_valid;

endmodule
`default_nettype wire

// File: rtl/multi_axis_step_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_axis_step_gen
//  Brief    : Multi-axis step/direction generator.  Shared slot/period timer,
//             write decode and sticky underrun flags around per-axis DDA
//             channels.
//  Revision : 1.0  initial release
// ============================================================================
module multi_axis_step_gen
   import multi_axis_step_pkg::*;
#(
   parameter int NUM_AXES  = 4,
   parameter int CNT_W     = CNT_W_DFLT,
   parameter int SLOTS     = 500,
   parameter int SLOT_DIV  = 400,
   parameter int PULSE_HI  = 200,
   parameter int DIR_SETUP = 20
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           run,
   input  logic                           wr,
   input  logic [idx_width(NUM_AXES)-1:0] wr_axis,
   input  logic [CNT_W:0]                 wr_data,
   input  logic                           clr_underrun,
   output logic [NUM_AXES-1:0]            step,
   output logic [NUM_AXES-1:0]            dir,
   output logic [NUM_AXES-1:0]            busy,
   output logic [NUM_AXES-1:0]            pend_valid,
   output logic [NUM_AXES-1:0]            underrun,
   output logic                           period_tick
);

   localparam int AX_W   = idx_width(NUM_AXES);
   localparam int ACC_W  = acc_width(SLOTS);
   localparam int DIV_W  = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   localparam logic [DIV_W-1:0]  c_div_last  = DIV_W'(SLOT_DIV - 1);
   localparam logic [DIV_W-1:0]  c_div_eval  = DIV_W'(DIR_SETUP);
   localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(SLOTS - 1);

   logic [DIV_W-1:0]    r_div;
   logic [SLOT_W-1:0]   r_slot;
   logic                r_run_d;
   logic                r_period_tick;
   logic [NUM_AXES-1:0] r_underrun;

   logic                w_wrap;
   logic                w_start;
   logic                w_boundary;
   logic                w_eval;
   logic [NUM_AXES-1:0] w_wr_sel;
   logic [NUM_AXES-1:0] w_ur_set;

   // The first running cycle after run rises acts as a boundary so the
   // channels load (or flag underrun) before slot 0 begins.
   assign w_start    = run & ~r_run_d;
   assign w_wrap     = run & r_run_d & (r_slot == c_slot_last) & (r_div == c_div_last);
   assign w_boundary = w_wrap | w_start;
   assign w_eval     = run & r_run_d & (r_div == c_div_eval);

   // Remember run so its rising edge can be detected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_d <= 1'b0;
      end else begin
         r_run_d <= run;
      end
   end

   // Slot divider and slot counter; both restart at every boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div  <= '0;
         r_slot <= '0;
      end else if (!run || w_boundary) begin
         r_div  <= '0;
         r_slot <= '0;
      end else if (r_div == c_div_last) begin
         r_div  <= '0;
         r_slot <= r_slot + 1'b1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // period_tick marks slot 0 / div 0 of each new period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period_tick <= 1'b0;
      end else begin
         r_period_tick <= w_boundary;
      end
   end

   // An axis underruns when a period starts with its pending buffer empty.
   assign w_ur_set = {NUM_AXES{w_boundary}} & ~pend_valid;

   // Sticky underrun flags; a new event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_underrun <= '0;
      end else begin
         r_underrun <= w_ur_set | (r_underrun & ~{NUM_AXES{clr_underrun}});
      end
   end

   generate
      for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
         assign w_wr_sel[i] = wr & (wr_axis == AX_W'(i));

         step_dda_channel #(
            .CNT_W    (CNT_W),
            .SLOTS    (SLOTS),
            .PULSE_HI (PULSE_HI),
            .ACC_W    (ACC_W)
         ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_run        (run),
            .i_boundary   (w_boundary),
            .i_eval       (w_eval),
            .i_wr         (w_wr_sel[i]),
            .i_wr_data    (wr_data),
            .o_step       (step[i]),
            .o_dir        (dir[i]),
            .o_busy       (busy[i]),
            .o_pend_valid (pend_valid[i])
         );
      end
   endgenerate

   assign underrun    = r_underrun;
   assign period_tick = r_period_tick;

endmodule
`default_nettype wire

// File: tb/tb_multi_axis_step_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_axis_step_gen
//  Brief    : Directed bench for multi_axis_step_gen with a per-period
//             scoreboard of pulse-slot masks, direction and busy.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_axis_step_gen;

   localparam int NA  = 2;
   localparam int SL  = 10;
   localparam int SD  = 8;
   localparam int PH  = 3;
   localparam int DS  = 2;

   logic          clk;
   logic          rst_n;
   logic          run;
   logic          wr;
   logic [0:0]    wr_axis;
   logic [9:0]    wr_data;
   logic          clr_underrun;
   logic [NA-1:0] step;
   logic [NA-1:0] dir;
   logic [NA-1:0] busy;
   logic [NA-1:0] pend_valid;
   logic [NA-1:0] underrun;
   logic          period_tick;

   multi_axis_step_gen #(
      .NUM_AXES  (NA),
      .CNT_W     (9),
      .SLOTS     (SL),
      .SLOT_DIV  (SD),
      .PULSE_HI  (PH),
      .DIR_SETUP (DS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .wr           (wr),
      .wr_axis      (wr_axis),
      .wr_data      (wr_data),
      .clr_underrun (clr_underrun),
      .step         (step),
      .dir          (dir),
      .busy         (busy),
      .pend_valid   (pend_valid),
      .underrun     (underrun),
      .period_tick  (period_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] m0;
      logic [9:0] m1;
      logic [1:0] d;
      logic [1:0] b;
   } exp_t;

   exp_t exp_q[$];

   // Pulse-slot masks for the counts used (slots where step rises).
   localparam logic [9:0] M_NONE = 10'h000;
   localparam logic [9:0] M_C4   = 10'h0A5;   // slots 0,2,5,7
   localparam logic [9:0] M_C5   = 10'h155;   // slots 0,2,4,6,8
   localparam logic [9:0] M_C7   = 10'h1B7;   // slots 0,1,2,4,5,7,8
   localparam logic [9:0] M_C9   = 10'h1FF;   // slots 0..8

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [9:0] m0, input logic [9:0] m1,
                       input logic [1:0] d, input logic [1:0] b);
      exp_t e;
      e.m0 = m0; e.m1 = m1; e.d = d; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic write(input int axis, input logic d, input int cnt);
      wr_axis = axis[0:0];
      wr_data = {d, 9'(cnt)};
      wr      = 1'b1;
      @(negedge clk);
      wr      = 1'b0;
   endtask

   task automatic wait_tick();
      bit got = 0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (period_tick) got = 1;
      end
      check("tick_timeout", 32'(got), 32'd1);
   endtask

   // ---------------- period monitor ----------------
   logic [9:0] mask [NA];
   logic [1:0] d_obs;
   logic [1:0] b_obs;
   logic [1:0] prev;
   int         hi [NA];
   int         cyc;
   bit         started = 0;

   task automatic compare_period();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("queue_underflow", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("mask_axis0", 32'(mask[0]), 32'(e.m0));
         check("mask_axis1", 32'(mask[1]), 32'(e.m1));
         check("period_dir", 32'(d_obs), 32'(e.d));
         check("period_busy", 32'(b_obs), 32'(e.b));
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         started = 0;
         prev    = '0;
         hi[0]   = 0;
         hi[1]   = 0;
      end else begin
         if (period_tick) begin
            if (started) compare_period();
            started = 1;
            cyc     = 0;
            mask[0] = '0;
            mask[1] = '0;
            d_obs   = dir;
            b_obs   = busy;
         end else begin
            cyc++;
         end
         for (int a = 0; a < NA; a++) begin
            if (step[a]) begin
               if (!prev[a]) begin
                  hi[a] = 1;
                  if (started && cyc < SL * SD) begin
                     mask[a][cyc / SD] = 1'b1;
                     check("rise_div", 32'(cyc % SD), 32'(DS + 1));
                  end
               end else begin
                  hi[a]++;
               end
            end else if (prev[a]) begin
               check("pulse_width", 32'(hi[a]), 32'(PH));
            end
         end
         prev = step;
      end
   end

   // Hard stop if the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=stall expected=finish");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0; run = 1'b0; wr = 1'b0; wr_axis = '0; wr_data = '0; clr_underrun = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_step",        32'(step),        32'd0);
      check("rst_dir",         32'(dir),         32'd0);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_pend_valid",  32'(pend_valid),  32'd0);
      check("rst_underrun",    32'(underrun),    32'd0);
      check("rst_period_tick", 32'(period_tick), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // P1: axis0 count 5 dir 1; axis1 never written -> underrun[1]
      write(0, 1'b1, 5);
      check("pend_after_write", 32'(pend_valid), 32'b01);
      push(M_C5, M_NONE, 2'b01, 2'b01);
      run = 1'b1;
      wait_tick();
      check("p1_dir",        32'(dir),        32'b01);
      check("p1_pend_valid", 32'(pend_valid), 32'b00);
      check("p1_underrun",   32'(underrun),   32'b10);

      // P2: count 9
      write(0, 1'b1, 9);
      push(M_C9, M_NONE, 2'b01, 2'b01);
      wait_tick();

      // P3: count 12 clamps to 9
      write(0, 1'b1, 12);
      push(M_C9, M_NONE, 2'b01, 2'b01);
      wait_tick();

      // P4: no write -> idle period, dir held
      push(M_NONE, M_NONE, 2'b01, 2'b00);
      wait_tick();
      check("p4_underrun", 32'(underrun), 32'b11);
      check("p4_busy",     32'(busy),     32'b00);
      clr_underrun = 1'b1;
      @(negedge clk);
      clr_underrun = 1'b0;
      check("clr_underrun", 32'(underrun), 32'b00);

      // P5: two writes, latest (7, dir 0) wins
      write(0, 1'b0, 3);
      write(0, 1'b0, 7);
      push(M_C7, M_NONE, 2'b00, 2'b01);
      wait_tick();

      // Write coincident with the P5->P6 boundary: P6 idle, P7 uses it
      push(M_NONE, M_NONE, 2'b00, 2'b00);
      repeat (SL * SD - 1) @(negedge clk);
      write(0, 1'b1, 5);
      check("p6_tick",       32'(period_tick), 32'd1);
      check("p6_underrun",   32'(underrun),    32'b11);
      check("p6_pend_valid", 32'(pend_valid),  32'b01);
      check("p6_busy",       32'(busy),        32'b00);

      // P7: axis1 count 4 dir 0 alongside axis0 count 5 dir 1
      write(1, 1'b0, 4);
      push(M_C5, M_C4, 2'b01, 2'b11);
      wait_tick();

      // P8 loads again; reset will cut it short
      write(0, 1'b1, 5);
      write(1, 1'b0, 4);
      wait_tick();
      repeat (DS + 1) @(negedge clk);
      check("pre_reset_step", 32'(step), 32'b11);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_step",        32'(step),        32'd0);
      check("async_rst_dir",         32'(dir),         32'd0);
      check("async_rst_busy",        32'(busy),        32'd0);
      check("async_rst_pend_valid",  32'(pend_valid),  32'd0);
      check("async_rst_underrun",    32'(underrun),    32'd0);
      check("async_rst_period_tick", 32'(period_tick), 32'd0);
      repeat (2) @(negedge clk);

      // Release with run still high: first period underruns on both axes
      push(M_NONE, M_NONE, 2'b00, 2'b00);
      rst_n = 1'b1;
      wait_tick();
      check("post_rst_underrun", 32'(underrun), 32'b11);
      check("post_rst_busy",     32'(busy),     32'b00);
      wait_tick();
      @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
